mcdf_fmt_rx: RTL and testbench
==============================

Name: mcdf_fmt_rx

Overview:
- Downstream receiver on the MCDF formatter output interface; it is the consumer end of the fmt_req/fmt_grant packet handshake.
- Arbitrates acceptance of each packet against its own buffer space, then captures the packet words into a FIFO.
- Checks framing (start, end, length) and replays words on a valid/ready stream tagged with channel id and last flag.
- Sits between the MCDF formatter port and the downstream sink or memory model.

Parameters:
- DATA_WIDTH, 32, width of fmt data words and output data.
- FIFO_DEPTH, 64, word entries in the receive buffer (power of 2, at least 32).
- START_TIMEOUT, 16, cycles allowed from grant to fmt_start before the packet is abandoned.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- fmt_req_i  in  1  formatter packet request.
- fmt_chid_i  in  2  channel id of the requested packet.
- fmt_length_i  in  6  packet length in words, sampled with fmt_req_i.
- fmt_grant_o  out  1  one-cycle grant pulse.
- fmt_data_i  in  DATA_WIDTH  packet data word.
- fmt_start_i  in  1  marks the first word.
- fmt_end_i  in  1  marks the last word.
- out_data_o  out  DATA_WIDTH  buffered word.
- out_chid_o  out  2  channel id of out_data_o.
- out_last_o  out  1  last word of the packet.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  sink accepts the word.
- err_len_o  out  1  sticky length or framing error.
- err_timeout_o  out  1  sticky start-timeout error.
- err_clr_i  in  1  clears both sticky errors.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, counters 0. Reset asserted mid-packet discards the packet and all buffered words.
- IDLE: on fmt_req_i=1, fmt_length_i!=0 and free entries >= fmt_length_i:
  - latch length and chid;
  - fmt_grant_o=1 on the next cycle, for exactly 1 cycle;
  - go to GRANT.
- fmt_req_i=1 with fmt_length_i=0: no grant; err_len_o set; stay in IDLE.
- Insufficient free space: wait in IDLE with no grant; re-evaluate every cycle.
- GRANT: go to WAIT_START; clear the timeout counter.
- WAIT_START:
  - fmt_start_i=1 → push word 1 and set count=1.
  - If fmt_end_i=1 in the same cycle, the packet completes (length 1 case) and the FSM returns to IDLE.
  - Otherwise go to RECV.
  - If START_TIMEOUT cycles pass with no start → set err_timeout_o, return to IDLE, push nothing.
  - fmt_end_i without fmt_start_i is ignored.
- RECV: every cycle pushes fmt_data_i and increments count; words are contiguous, with no valid qualifier beyond the state.
  - fmt_end_i with count==length → that word gets last=1; return to IDLE.
  - fmt_end_i with count!=length → last=1; set err_len_o; return to IDLE.
  - count reaching length without fmt_end_i → force last=1 on that word; set err_len_o; return to IDLE; later words are dropped.
  - fmt_start_i in RECV → set err_len_o; word still pushed.
- Overflow: cannot occur. Space is reserved at grant, only one packet is in flight, and pops only add space.
- FIFO entry = {data, chid, last}.
- Output stream:
  - out_valid_o=1 whenever the FIFO is non-empty.
  - Pop on out_valid_o && out_ready_i.
  - Push and pop in the same cycle are allowed.
  - Output is registered from the FIFO head; first word is visible 1 cycle after its push.
  - Sustained throughput is 1 word per cycle.
- Free-space compare uses full occupancy count (0..FIFO_DEPTH), with no wrap ambiguity.
- Sticky errors: remain set until err_clr_i or rst_i. A simultaneous set and clear leaves the error set.
- fmt_grant_o is never asserted outside IDLE→GRANT.

Optional Feature:
- Macro: MCDF_FMT_RX_STATS_EN.
- When defined:
  - adds outputs pkt_cnt0_o, pkt_cnt1_o, pkt_cnt2_o (16 bits each);
  - a counter increments when a packet of that chid completes without error;
  - counters wrap from 0xFFFF to 0;
  - chid 3 is not counted;
  - counters are cleared by rst_i only.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Basic packet: fmt_req_i=1, chid=1, length=4; data 0xA0..0xA3 with start on word 0 and end on word 3; out_ready_i=1. Expect one grant pulse 1 cycle after req, 4 output words with chid=1, last only on 0xA3, no errors.
- Backpressure/space: FIFO_DEPTH=64, out_ready_i=0, two length-32 packets, then a request of length 4. Expect no third grant until out_ready_i=1 has popped at least 4 words; grant then issued.
- Short packet: length=8, fmt_end_i on word 5. Expect 5 words, last on word 5, err_len_o=1; err_clr_i pulse clears it.
- Long packet: length=4, no end until word 6. Expect 4 words stored, last forced on word 4, words 5-6 dropped, err_len_o=1.
- Timeout and reset: grant then no start for 16 cycles → err_timeout_o=1 and FSM back in IDLE. Separately, rst_i mid-packet → out_valid_o=0 next cycle and a new request is granted normally.
- Stats (macro defined): 3 clean packets on chid 2 plus 1 erroneous packet on chid 2. Expect pkt_cnt2_o=3 and other counters 0.

Source files
------------

// File: rtl/mcdf_fmt_rx.sv
// mcdf_fmt_rx: consumer end of the MCDF formatter packet handshake.
// A packet is granted only when the receive buffer can hold all of its words.
// Its words are then captured with framing checks (start, end, length) and
// replayed on a valid/ready stream tagged with channel id and last flag.
// Optional build macro MCDF_FMT_RX_STATS_EN adds per-channel clean-packet counters.
module mcdf_fmt_rx #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 64,
    parameter int START_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fmt_req_i,
    input  logic [1:0]            fmt_chid_i,
    input  logic [5:0]            fmt_length_i,
    output logic                  fmt_grant_o,
    input  logic [DATA_WIDTH-1:0] fmt_data_i,
    input  logic                  fmt_start_i,
    input  logic                  fmt_end_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            out_chid_o,
    output logic                  out_last_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  err_len_o,
    output logic                  err_timeout_o,
    input  logic                  err_clr_i
`ifdef MCDF_FMT_RX_STATS_EN
    ,
    output logic [15:0]           pkt_cnt0_o,
    output logic [15:0]           pkt_cnt1_o,
    output logic [15:0]           pkt_cnt2_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;                       // occupancy 0..FIFO_DEPTH
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int EW = DATA_WIDTH + 3;               // {data, chid, last}

    localparam logic [TW-1:0] TO_MAX   = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] DEPTH_CW = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_RECV       = 2'd3
    } state_t;

    // Control state
    state_t         state_q, state_d;
    logic [5:0]     len_q, len_d;
    logic [1:0]     chid_q, chid_d;
    logic [5:0]     wcnt_q, wcnt_d;
    logic [TW-1:0]  to_q, to_d;
    logic           grant_q, grant_d;
    logic           err_len_q, err_len_d;
    logic           err_to_q, err_to_d;

    // Per-cycle FSM decisions
    logic           push_s;
    logic           push_last_s;
    logic           word_err_s;
    logic           zero_len_s;
    logic           to_err_s;
    logic [5:0]     wcnt_inc_s;

    // Buffer: memory plus one registered output stage; occupancy counts both
    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  mem_cnt_q, mem_cnt_d;
    logic [EW-1:0]  out_ent_q, out_ent_d;
    logic           out_valid_q, out_valid_d;

    logic [CW-1:0]  occ_s;
    logic [CW-1:0]  free_s;
    logic [EW-1:0]  push_ent_s;
    logic           pop_s;
    logic           load_s;
    logic           bypass_s;
    logic           mem_wr_s;
    logic           mem_rd_s;

    assign occ_s      = mem_cnt_q + CW'(out_valid_q);
    assign free_s     = DEPTH_CW - occ_s;
    assign push_ent_s = {fmt_data_i, chid_q, push_last_s};

    // Packet FSM next state: grant arbitration, start timeout and framing checks
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        chid_d      = chid_q;
        wcnt_d      = wcnt_q;
        to_d        = to_q;
        grant_d     = 1'b0;
        push_s      = 1'b0;
        push_last_s = 1'b0;
        word_err_s  = 1'b0;
        zero_len_s  = 1'b0;
        to_err_s    = 1'b0;
        wcnt_inc_s  = wcnt_q + 6'd1;
        case (state_q)
            ST_IDLE: begin
                if (fmt_req_i) begin
                    if (fmt_length_i == 6'd0) begin
                        zero_len_s = 1'b1;
                    end else if (free_s >= CW'(fmt_length_i)) begin
                        len_d   = fmt_length_i;
                        chid_d  = fmt_chid_i;
                        grant_d = 1'b1;
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_IDLE;          // wait for the sink to free space
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                to_d    = {TW{1'b0}};
                wcnt_d  = 6'd0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (fmt_start_i) begin
                    push_s = 1'b1;
                    wcnt_d = 6'd1;
                    if (fmt_end_i) begin
                        push_last_s = 1'b1;
                        word_err_s  = (len_q != 6'd1);
                        state_d     = ST_IDLE;
                    end else if (len_q == 6'd1) begin
                        push_last_s = 1'b1;         // length reached without end
                        word_err_s  = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else if (to_q == TO_MAX) begin
                    to_err_s = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    to_d = to_q + TO_ONE;
                end
            end
            ST_RECV: begin
                push_s = 1'b1;
                wcnt_d = wcnt_inc_s;
                if (fmt_end_i) begin
                    push_last_s = 1'b1;
                    word_err_s  = fmt_start_i | (wcnt_inc_s != len_q);
                    state_d     = ST_IDLE;
                end else if (wcnt_inc_s == len_q) begin
                    push_last_s = 1'b1;             // truncate: later words are dropped
                    word_err_s  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    word_err_s = fmt_start_i;
                    state_d    = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Sticky errors: a set in the same cycle as a clear wins
        err_len_d = (zero_len_s | word_err_s) | (err_len_q & ~err_clr_i);
        err_to_d  = to_err_s | (err_to_q & ~err_clr_i);
    end

    // Buffer next state: output stage refills from memory, or straight from the input when memory is empty
    always_comb begin
        pop_s    = out_valid_q & out_ready_i;
        load_s   = (~out_valid_q | pop_s) & ((mem_cnt_q != {CW{1'b0}}) | push_s);
        bypass_s = load_s & (mem_cnt_q == {CW{1'b0}});
        mem_wr_s = push_s & ~bypass_s;
        mem_rd_s = load_s & (mem_cnt_q != {CW{1'b0}});

        wr_ptr_d  = mem_wr_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = mem_rd_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        if (mem_wr_s && !mem_rd_s) begin
            mem_cnt_d = mem_cnt_q + CNT_ONE;
        end else if (!mem_wr_s && mem_rd_s) begin
            mem_cnt_d = mem_cnt_q - CNT_ONE;
        end else begin
            mem_cnt_d = mem_cnt_q;
        end

        if (load_s) begin
            out_valid_d = 1'b1;
            out_ent_d   = bypass_s ? push_ent_s : mem_q[rd_ptr_q];
        end else if (pop_s) begin
            out_valid_d = 1'b0;
            out_ent_d   = out_ent_q;
        end else begin
            out_valid_d = out_valid_q;
            out_ent_d   = out_ent_q;
        end
    end

    // Control and buffer registers; reset discards any packet in flight and all buffered words
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= 6'd0;
            chid_q      <= 2'd0;
            wcnt_q      <= 6'd0;
            to_q        <= {TW{1'b0}};
            grant_q     <= 1'b0;
            err_len_q   <= 1'b0;
            err_to_q    <= 1'b0;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            mem_cnt_q   <= {CW{1'b0}};
            out_ent_q   <= {EW{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            chid_q      <= chid_d;
            wcnt_q      <= wcnt_d;
            to_q        <= to_d;
            grant_q     <= grant_d;
            err_len_q   <= err_len_d;
            err_to_q    <= err_to_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_ent_q   <= out_ent_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Word storage; contents need no reset because occupancy tracking guards every read
    always_ff @(posedge clk_i) begin
        if (mem_wr_s) begin
            mem_q[wr_ptr_q] <= push_ent_s;
        end
    end

    assign fmt_grant_o   = grant_q;
    assign out_data_o    = out_ent_q[EW-1:3];
    assign out_chid_o    = out_ent_q[2:1];
    assign out_last_o    = out_ent_q[0];
    assign out_valid_o   = out_valid_q;
    assign err_len_o     = err_len_q;
    assign err_timeout_o = err_to_q;

`ifdef MCDF_FMT_RX_STATS_EN
    logic        pkt_err_q, pkt_err_d;
    logic        done_ok_s;
    logic [15:0] pkt_cnt_q [3];
    logic [15:0] pkt_cnt_d [3];

    // A packet counts only if none of its words raised a framing error
    assign done_ok_s = push_last_s & ~pkt_err_q & ~word_err_s;

    // Clean-packet counters per channel; channel 3 is not counted and counters wrap
    always_comb begin
        if (state_q == ST_GRANT) begin
            pkt_err_d = 1'b0;
        end else begin
            pkt_err_d = pkt_err_q | word_err_s;
        end
        for (int i = 0; i < 3; i++) begin
            if (done_ok_s && (chid_q == 2'(i))) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + 16'd1;
            end else begin
                pkt_cnt_d[i] = pkt_cnt_q[i];
            end
        end
    end

    // Statistics registers, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_err_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                pkt_cnt_q[i] <= 16'd0;
            end
        end else begin
            pkt_err_q <= pkt_err_d;
            for (int i = 0; i < 3; i++) begin
                pkt_cnt_q[i] <= pkt_cnt_d[i];
            end
        end
    end

    assign pkt_cnt0_o = pkt_cnt_q[0];
    assign pkt_cnt1_o = pkt_cnt_q[1];
    assign pkt_cnt2_o = pkt_cnt_q[2];
`endif

endmodule

// File: tb/tb_mcdf_fmt_rx.sv
// Testbench for mcdf_fmt_rx: scoreboard of expected output words, filled as
// packet words are driven and drained by a monitor on the output stream.
module tb_mcdf_fmt_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int TMO   = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          fmt_req_i;
    logic [1:0]    fmt_chid_i;
    logic [5:0]    fmt_length_i;
    logic          fmt_grant_o;
    logic [DW-1:0] fmt_data_i;
    logic          fmt_start_i;
    logic          fmt_end_i;
    logic [DW-1:0] out_data_o;
    logic [1:0]    out_chid_o;
    logic          out_last_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          err_len_o;
    logic          err_timeout_o;
    logic          err_clr_i;
`ifdef MCDF_FMT_RX_STATS_EN
    logic [15:0]   pkt_cnt0_o;
    logic [15:0]   pkt_cnt1_o;
    logic [15:0]   pkt_cnt2_o;
`endif

    always #5 clk_i = ~clk_i;

    mcdf_fmt_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .START_TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fmt_req_i(fmt_req_i), .fmt_chid_i(fmt_chid_i), .fmt_length_i(fmt_length_i),
        .fmt_grant_o(fmt_grant_o), .fmt_data_i(fmt_data_i),
        .fmt_start_i(fmt_start_i), .fmt_end_i(fmt_end_i),
        .out_data_o(out_data_o), .out_chid_o(out_chid_o), .out_last_o(out_last_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .err_len_o(err_len_o), .err_timeout_o(err_timeout_o), .err_clr_i(err_clr_i)
`ifdef MCDF_FMT_RX_STATS_EN
        , .pkt_cnt0_o(pkt_cnt0_o), .pkt_cnt1_o(pkt_cnt1_o), .pkt_cnt2_o(pkt_cnt2_o)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    chid;
        logic          last;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   pop_cnt     = 0;
    bit   rand_ready  = 1'b0;

    // Output monitor: every accepted word must match the head of the scoreboard
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            pop_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_word: got data=%h chid=%0d last=%0b, expected no word",
                         out_data_o, out_chid_o, out_last_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_data_o, out_chid_o, out_last_o} !== mon_e) begin
                    miscompares++;
                    $display("FAIL out_word: got data=%h chid=%0d last=%0b, expected data=%h chid=%0d last=%0b",
                             out_data_o, out_chid_o, out_last_o, mon_e.data, mon_e.chid, mon_e.last);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task tick;
        @(posedge clk_i);
        #1;
    endtask

    // Hold a request until granted or max_wait cycles pass
    task automatic request(input logic [1:0] chid, input logic [5:0] len, input int max_wait,
                           output bit granted, output int waited);
        fmt_req_i    = 1'b1;
        fmt_chid_i   = chid;
        fmt_length_i = len;
        granted      = 1'b0;
        waited       = 0;
        while (!granted && waited < max_wait) begin
            tick();
            waited++;
            if (fmt_grant_o === 1'b1) granted = 1'b1;
        end
        fmt_req_i = 1'b0;
    endtask

    // Called in the grant cycle: drive nwords words, end flag on word end_at (0 = never)
    task automatic drive_words(input logic [1:0] chid, input int len, input int nwords,
                               input int end_at, input logic [DW-1:0] base);
        int   stop;
        ent_t e;
        stop = (end_at > 0 && end_at < len) ? end_at : len;
        tick();
        vectors++;
        if (fmt_grant_o !== 1'b0) begin
            miscompares++;
            $display("FAIL grant_pulse: got %b, expected 0 one cycle after grant", fmt_grant_o);
        end
        for (int i = 1; i <= nwords; i++) begin
            fmt_data_i  = base + DW'(i - 1);
            fmt_start_i = (i == 1);
            fmt_end_i   = (i == end_at);
            if (i <= stop) begin
                e.data = base + DW'(i - 1);
                e.chid = chid;
                e.last = (i == stop);
                exp_q.push_back(e);
            end
            if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        fmt_start_i = 1'b0;
        fmt_end_i   = 1'b0;
        fmt_data_i  = '0;
    endtask

    task automatic send_pkt(input logic [1:0] chid, input int len, input int nwords,
                            input int end_at, input logic [DW-1:0] base);
        bit g;
        int w;
        request(chid, 6'(len), 400, g, w);
        vectors++;
        if (!g) begin
            miscompares++;
            $display("FAIL grant_wait: got no grant in %0d cycles, expected a grant", w);
        end else begin
            drive_words(chid, len, nwords, end_at, base);
        end
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid_o !== 1'b0) && n < max) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: got %0d words outstanding valid=%b, expected 0 and 0",
                     exp_q.size(), out_valid_o);
        end
    endtask

    task automatic clear_errors;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        fmt_req_i = 1'b0; fmt_chid_i = 2'd0; fmt_length_i = 6'd0;
        fmt_data_i = '0; fmt_start_i = 1'b0; fmt_end_i = 1'b0;
        out_ready_i = 1'b0; err_clr_i = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({fmt_grant_o, out_valid_o, out_last_o, out_chid_o, out_data_o, err_len_o, err_timeout_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got grant=%b valid=%b last=%b chid=%0d data=%h elen=%b eto=%b, expected all 0",
                     fmt_grant_o, out_valid_o, out_last_o, out_chid_o, out_data_o, err_len_o, err_timeout_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        bit g;
        int w;
        out_ready_i = 1'b1;
        request(2'd1, 6'd4, 10, g, w);
        vectors++;
        if (!g || w != 1) begin
            miscompares++;
            $display("FAIL basic_grant_latency: got granted=%b after %0d cycles, expected grant after 1", g, w);
        end
        if (g) drive_words(2'd1, 4, 4, 4, 32'hA0);
        wait_drain(20);
        vectors++;
        if ({err_len_o, err_timeout_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_errors: got elen=%b eto=%b, expected 0 0", err_len_o, err_timeout_o);
        end
    endtask

    task automatic test_back_to_back;
        int lens [4];
        lens[0] = 1; lens[1] = 3; lens[2] = 7; lens[3] = 63;
        rand_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            send_pkt(2'(p), lens[p], lens[p], lens[p], 32'h1000 * (p + 1));
        end
        rand_ready  = 1'b0;
        out_ready_i = 1'b1;
        wait_drain(200);
        vectors++;
        if (err_len_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_err_len: got %b, expected 0", err_len_o);
        end
    endtask

    task automatic test_zero_len;
        fmt_req_i = 1'b1; fmt_length_i = 6'd0; fmt_chid_i = 2'd2; err_clr_i = 1'b1;
        tick();
        fmt_req_i = 1'b0; err_clr_i = 1'b0;
        vectors++;
        if (err_len_o !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_len_set_wins: got err_len=%b, expected 1", err_len_o);
        end
        tick();
        vectors++;
        if (fmt_grant_o !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_grant: got %b, expected 0", fmt_grant_o);
        end
        clear_errors();
        vectors++;
        if (err_len_o !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_clear: got err_len=%b, expected 0", err_len_o);
        end
    endtask

    task automatic test_short;
        out_ready_i = 1'b1;
        send_pkt(2'd2, 8, 5, 5, 32'hB0);
        wait_drain(20);
        vectors++;
        if (err_len_o !== 1'b1) begin
            miscompares++;
            $display("FAIL short_err_len: got %b, expected 1", err_len_o);
        end
        clear_errors();
        vectors++;
        if (err_len_o !== 1'b0) begin
            miscompares++;
            $display("FAIL short_err_clear: got %b, expected 0", err_len_o);
        end
    endtask

    task automatic test_long;
        out_ready_i = 1'b1;
        send_pkt(2'd0, 4, 6, 6, 32'hC0);
        wait_drain(20);
        vectors++;
        if (err_len_o !== 1'b1) begin
            miscompares++;
            $display("FAIL long_err_len: got %b, expected 1", err_len_o);
        end
        clear_errors();
    endtask

    task automatic test_backpressure;
        bit g;
        int w;
        out_ready_i = 1'b0;
        send_pkt(2'd1, 32, 32, 32, 32'h100);
        send_pkt(2'd2, 32, 32, 32, 32'h200);
        request(2'd3, 6'd4, 8, g, w);
        vectors++;
        if (g) begin
            miscompares++;
            $display("FAIL bp_no_grant_full: got grant, expected none with buffer full");
        end
        // Four pops free four entries; IDLE sees the space the cycle after the
        // fourth pop and the registered grant appears one cycle later, by which
        // time a fifth word has been popped.
        fmt_req_i = 1'b1; fmt_chid_i = 2'd3; fmt_length_i = 6'd4;
        pop_cnt = 0;
        out_ready_i = 1'b1;
        g = 1'b0; w = 0;
        while (!g && w < 20) begin
            tick();
            w++;
            if (fmt_grant_o === 1'b1) g = 1'b1;
        end
        fmt_req_i = 1'b0;
        vectors++;
        if (!g || pop_cnt != 5) begin
            miscompares++;
            $display("FAIL bp_grant_after_pops: got granted=%b pops=%0d, expected grant with 5 pops", g, pop_cnt);
        end
        if (g) drive_words(2'd3, 4, 4, 4, 32'h300);
        wait_drain(200);
    endtask

    task automatic test_timeout;
        bit g;
        int w;
        out_ready_i = 1'b1;
        request(2'd0, 6'd4, 10, g, w);
        vectors++;
        if (!g) begin
            miscompares++;
            $display("FAIL to_grant: got no grant, expected grant");
        end
        repeat (12) tick();
        vectors++;
        if (err_timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL to_early: got err_timeout=%b after 12 cycles, expected 0", err_timeout_o);
        end
        repeat (5) tick();
        vectors++;
        if (err_timeout_o !== 1'b1 || out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL to_set: got err_timeout=%b valid=%b, expected 1 0", err_timeout_o, out_valid_o);
        end
        clear_errors();
        vectors++;
        if (err_timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL to_clear: got %b, expected 0", err_timeout_o);
        end
        send_pkt(2'd1, 2, 2, 2, 32'hD0);
        wait_drain(20);
    endtask

    task automatic test_reset_mid;
        bit g;
        int w;
        out_ready_i = 1'b0;
        request(2'd2, 6'd8, 10, g, w);
        tick();
        fmt_data_i = 32'hE0; fmt_start_i = 1'b1;
        tick();
        fmt_data_i = 32'hE1; fmt_start_i = 1'b0;
        tick();
        rst_i = 1'b1;
        fmt_data_i = '0;
        tick();
        vectors++;
        if (out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_valid: got %b, expected 0", out_valid_o);
        end
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        send_pkt(2'd1, 3, 3, 3, 32'hF0);
        wait_drain(20);
    endtask

`ifdef MCDF_FMT_RX_STATS_EN
    task automatic test_stats;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        for (int p = 0; p < 3; p++) send_pkt(2'd2, 3, 3, 3, 32'h500 + 32'(p * 16));
        send_pkt(2'd2, 4, 2, 2, 32'h600);
        send_pkt(2'd3, 2, 2, 2, 32'h700);
        wait_drain(50);
        vectors++;
        if (pkt_cnt2_o !== 16'd3 || pkt_cnt0_o !== 16'd0 || pkt_cnt1_o !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_counts: got c0=%0d c1=%0d c2=%0d, expected 0 0 3",
                     pkt_cnt0_o, pkt_cnt1_o, pkt_cnt2_o);
        end
        clear_errors();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_len();
        test_short();
        test_long();
        test_backpressure();
        test_timeout();
        test_reset_mid();
`ifdef MCDF_FMT_RX_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
